dmem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-port data memory between the CPU load/store path (port 0) and the program/data loader (port 1).
- Uses a req/gnt handshake and routes synchronous read data back to the owning requester one cycle after acceptance.
- Round-robin by default. Accepts back-to-back transactions, one per cycle.
- Produces a CPU stall signal so the core's PC register holds while a CPU access is pending.

---
 rtl/dmem_arbiter_if.sv | 23 ++
 rtl/dmem_arbiter.sv | 113 +++++++++++
 tb/tb_dmem_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: one instance per port.
// master = requester (CPU or loader), slave = arbiter.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing the single-port data memory between the CPU
// load/store path (p0) and the program/data loader (p1). One acceptance per
// cycle; read data returns to the owner the cycle after acceptance.
// Optional build macro DMEM_ARB_CPU_PRIO_EN: p0 always wins a tie (fixed
// priority). Without it, ties alternate by round-robin on last_gnt.
module dmem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    dmem_arbiter_if.slave     p0,
    dmem_arbiter_if.slave     p1,
    output logic              cpu_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // last_gnt: 0 = p0 won last, 1 = p1 won last (reset to 1 so p0 wins the first tie)
    logic last_gnt_q, last_gnt_d;
    logic pend_valid_q, pend_valid_d;
    logic pend_owner_q, pend_owner_d;

    logic gnt0_c, gnt1_c;
    logic rvalid0_c, rvalid1_c;

    // Byte address bits below the word and above the depth are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{p0.addr[31:ADDR_W+2], p0.addr[1:0],
                                p1.addr[31:ADDR_W+2], p1.addr[1:0]};

`ifdef DMEM_ARB_CPU_PRIO_EN
    logic unused_last_gnt;
    assign unused_last_gnt = last_gnt_q;
`endif

    // Grant decision: one winner per cycle, nothing granted while in reset.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!reset) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
            gnt0_c = p0.req;
`else
            gnt0_c = p0.req & (~p1.req | last_gnt_q);
`endif
            gnt1_c = p1.req & ~gnt0_c;
        end
    end

    // Memory strobe and winner's command muxed onto the memory bus.
    always_comb begin
        mem_en    = gnt0_c | gnt1_c;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0_c) begin
            mem_we    = p0.we;
            mem_addr  = p0.addr[ADDR_W+1:2];
            mem_wdata = p0.wdata;
        end else if (gnt1_c) begin
            mem_we    = p1.we;
            mem_addr  = p1.addr[ADDR_W+1:2];
            mem_wdata = p1.wdata;
        end
    end

    // Next-state: remember the winner and tag an accepted read with its owner.
    always_comb begin
        last_gnt_d   = last_gnt_q;
        pend_valid_d = mem_en & ~mem_we;
        pend_owner_d = pend_owner_q;
        if (mem_en) begin
            last_gnt_d   = gnt1_c;
            pend_owner_d = gnt1_c;
        end
    end

    // State registers; reset drops any in-flight read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt_q   <= 1'b1;
            pend_valid_q <= 1'b0;
            pend_owner_q <= 1'b0;
        end else begin
            last_gnt_q   <= last_gnt_d;
            pend_valid_q <= pend_valid_d;
            pend_owner_q <= pend_owner_d;
        end
    end

    // Read response routed to the owner of the previous acceptance; the other port sees zero.
    always_comb begin
        rvalid0_c = pend_valid_q & ~pend_owner_q;
        rvalid1_c = pend_valid_q &  pend_owner_q;
        p0.gnt    = gnt0_c;
        p1.gnt    = gnt1_c;
        p0.rvalid = rvalid0_c;
        p1.rvalid = rvalid1_c;
        p0.rdata  = rvalid0_c ? mem_rdata : '0;
        p1.rdata  = rvalid1_c ? mem_rdata : '0;
    end

    // CPU stall: waiting for a grant, or a CPU read whose data is not yet presented.
    always_comb begin
        cpu_stall = ~reset & ((p0.req & ~gnt0_c) |
                              (pend_valid_q & ~pend_owner_q & ~rvalid0_c));
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, checked
// against a transaction-level reference (request queues, shadow memory).
module tb_dmem_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(DATA_W)) p0_if ();
    dmem_arbiter_if #(.DATA_W(DATA_W)) p1_if ();

    logic              cpu_stall;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .p0        (p0_if),
        .p1        (p1_if),
        .cpu_stall (cpu_stall),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // Synchronous single-port memory attached to the arbiter.
    logic [DATA_W-1:0] tb_mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) tb_mem[mem_addr] = mem_wdata;
                else        mem_rdata = tb_mem[mem_addr];
            end
        end
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        q0[$];
    txn_t        q1[$];
    logic [31:0] ref_mem [DEPTH];
    int          ref_last;
    bit          rst_m;
    bit          pend;
    int          pend_own;
    logic [31:0] pend_data;
    int          n_cmp;
    int          n_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: present queue heads, check at negedge, advance the model at posedge.
    task automatic step();
        bit          r0, r1;
        int          win;
        txn_t        t;
        logic [31:0] widx;
        r0 = q0.size() > 0;
        r1 = q1.size() > 0;
        p0_if.req   = r0;
        p0_if.we    = r0 ? q0[0].we    : 1'($urandom);
        p0_if.addr  = r0 ? q0[0].addr  : $urandom;
        p0_if.wdata = r0 ? q0[0].wdata : $urandom;
        p1_if.req   = r1;
        p1_if.we    = r1 ? q1[0].we    : 1'($urandom);
        p1_if.addr  = r1 ? q1[0].addr  : $urandom;
        p1_if.wdata = r1 ? q1[0].wdata : $urandom;
        @(negedge clk);
        win = -1;
        if (!rst_m) begin
            if (r0 && r1) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
                win = 0;
`else
                win = (ref_last == 0) ? 1 : 0;
`endif
            end else if (r0) win = 0;
            else if (r1)     win = 1;
        end
        t = '{1'b0, 32'h0, 32'h0};
        if (win == 0) t = q0[0];
        if (win == 1) t = q1[0];
        widx = (t.addr >> 2) % 32'(DEPTH);
        chk("p0_gnt", 32'(p0_if.gnt), 32'(win == 0));
        chk("p1_gnt", 32'(p1_if.gnt), 32'(win == 1));
        chk("mem_en", 32'(mem_en), 32'(win >= 0));
        chk("mem_we", 32'(mem_we), 32'(win >= 0 && t.we));
        if (win >= 0) begin
            chk("mem_addr", 32'(mem_addr), widx);
            if (t.we) chk("mem_wdata", mem_wdata, t.wdata);
        end
        chk("p0_rvalid", 32'(p0_if.rvalid), 32'(pend && pend_own == 0));
        chk("p1_rvalid", 32'(p1_if.rvalid), 32'(pend && pend_own == 1));
        chk("p0_rdata", p0_if.rdata, (pend && pend_own == 0) ? pend_data : 32'h0);
        chk("p1_rdata", p1_if.rdata, (pend && pend_own == 1) ? pend_data : 32'h0);
        chk("cpu_stall", 32'(cpu_stall), 32'(!rst_m && r0 && win != 0));
        @(posedge clk);
        pend = 1'b0;
        if (win >= 0) begin
            if (t.we) ref_mem[widx[ADDR_W-1:0]] = t.wdata;
            else begin
                pend      = 1'b1;
                pend_own  = win;
                pend_data = ref_mem[widx[ADDR_W-1:0]];
            end
            ref_last = win;
            if (win == 0) void'(q0.pop_front());
            else          void'(q1.pop_front());
        end
        #1;
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = {$urandom_range(0, 3) == 0 ? 22'($urandom) : 22'h0,
                   8'($urandom_range(0, 15)), 2'($urandom)};
        t.wdata = $urandom;
        return t;
    endfunction

    initial begin
        n_cmp = 0; n_bad = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        reset = 1'b1; rst_m = 1'b1; ref_last = 1; pend = 1'b0; pend_own = 0; pend_data = '0;
        p0_if.req = 1'b0; p0_if.we = 1'b0; p0_if.addr = '0; p0_if.wdata = '0;
        p1_if.req = 1'b0; p1_if.we = 1'b0; p1_if.addr = '0; p1_if.wdata = '0;
        #1;
        step(); step();
        reset = 1'b0; rst_m = 1'b0;

        // loader write then CPU read of the same word
        q1.push_back('{1'b1, 32'h10, 32'hDEAD_BEEF});
        step();
        q0.push_back('{1'b0, 32'h10, 32'h0});
        step(); step();

        // address above the depth wraps
        q0.push_back('{1'b0, 32'h404, 32'h0});
        step(); step();

        // back-to-back CPU loads
        q0.push_back('{1'b0, 32'h0, 32'h0});
        q0.push_back('{1'b0, 32'h4, 32'h0});
        q0.push_back('{1'b0, 32'h8, 32'h0});
        repeat (4) step();

        // reset lands between a CPU read grant and its response
        q0.push_back('{1'b0, 32'h8, 32'h0});
        step();
        reset = 1'b1; rst_m = 1'b1; pend = 1'b0; ref_last = 1;
        step(); step();
        reset = 1'b0; rst_m = 1'b0;

        // both ports contend with reads
        for (int i = 0; i < 3; i++) begin
            q0.push_back('{1'b0, 32'(i * 4), 32'h0});
            q1.push_back('{1'b0, 32'(i * 4 + 64), 32'h0});
        end
        repeat (7) step();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            if (q0.size() == 0 && $urandom_range(0, 3) != 0) q0.push_back(rand_txn());
            if (q1.size() == 0 && $urandom_range(0, 2) != 0) q1.push_back(rand_txn());
            step();
        end
        for (int c = 0; c < 50 && (q0.size() + q1.size()) > 0; c++) step();
        chk("drain", 32'(q0.size() + q1.size()), 32'h0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
